sram_wr_sched: RTL and testbench

//  Strict-priority packet scheduler between the per-priority ingress FIFOs and the SRAM write port.

---
 rtl/sram_wr_sched_pkg.sv | 33 +++
 rtl/sram_wr_sched_if.sv | 46 ++++
 rtl/sram_wr_sched_prio_enc.sv | 29 ++
 rtl/sram_wr_sched.sv | 145 ++++++++++++++
 tb/tb_sram_wr_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_wr_sched_pkg.sv
// sram_wr_sched_pkg
//   Shared definitions for the SRAM write scheduler: default geometry,
//   a constant-foldable clog2 helper, derived widths and the FSM state type.
//   No ports; imported by the interface, the priority encoder and the top.
package sram_wr_sched_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_NUM_PRIORITY = 8;
    localparam int DEF_FIFO_LENGTH  = 32;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    localparam int DEF_PRIO_W = clog2(DEF_NUM_PRIORITY);
    localparam int DEF_FREE_W = clog2(DEF_FIFO_LENGTH * DEF_NUM_PRIORITY) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sram_wr_sched_if.sv
// sram_wr_sched_if
//   Bundles the per-priority FIFO read side and the SRAM write side of the
//   scheduler.
//   FIFO side : q_ready, q_sop, q_eop, q_vld (N bits each), q_data (N*W),
//               q_next (N, driven by the scheduler).
//   SRAM side : sram_free (free words), sram_wr_sop/eop/vld/data/prio,
//               pkt_err (overlong packet pulse), busy (scheduler not idle).
//   master = the scheduler, slave = the surrounding FIFOs/SRAM.
interface sram_wr_sched_if
    import sram_wr_sched_pkg::*;
#(
    parameter int data_w   = DEF_DATA_WIDTH,
    parameter int num_prio = DEF_NUM_PRIORITY,
    parameter int prio_w   = DEF_PRIO_W,
    parameter int free_w   = DEF_FREE_W
);

    logic [num_prio-1:0]        q_ready;
    logic [num_prio-1:0]        q_sop;
    logic [num_prio-1:0]        q_eop;
    logic [num_prio-1:0]        q_vld;
    logic [num_prio*data_w-1:0] q_data;
    logic [num_prio-1:0]        q_next;

    logic [free_w-1:0]          sram_free;
    logic                       sram_wr_sop;
    logic                       sram_wr_eop;
    logic                       sram_wr_vld;
    logic [data_w-1:0]          sram_wr_data;
    logic [prio_w-1:0]          sram_wr_prio;
    logic                       pkt_err;
    logic                       busy;

    modport master (
        input  q_ready, q_sop, q_eop, q_vld, q_data, sram_free,
        output q_next, sram_wr_sop, sram_wr_eop, sram_wr_vld,
               sram_wr_data, sram_wr_prio, pkt_err, busy
    );

    modport slave (
        output q_ready, q_sop, q_eop, q_vld, q_data, sram_free,
        input  q_next, sram_wr_sop, sram_wr_eop, sram_wr_vld,
               sram_wr_data, sram_wr_prio, pkt_err, busy
    );

endinterface

// File: rtl/sram_wr_sched_prio_enc.sv
// sram_wr_sched_prio_enc
//   Purely combinational strict-priority encoder: index 0 wins.
//   req   in  N        request vector
//   idx   out clog2(N) lowest set index (0 when nothing is set)
//   valid out 1        at least one request bit set
module sram_wr_sched_prio_enc
    import sram_wr_sched_pkg::*;
#(
    parameter int num_req = DEF_NUM_PRIORITY,
    parameter int idx_w   = clog2(num_req)
) (
    input  logic [num_req-1:0] req,
    output logic [idx_w-1:0]   idx,
    output logic               valid
);

    // Scan from the top down so the last hit, the lowest set index, wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = num_req - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = idx_w'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_wr_sched.sv
// sram_wr_sched
//   Strict-priority packet scheduler from the per-priority ingress FIFOs to
//   the SRAM write port. One whole packet is moved per grant; packets never
//   interleave and every forwarded word is tagged with its priority.
//   clk  in  system clock
//   rst  in  synchronous, active-high reset
//   bus  master side of sram_wr_sched_if (FIFO read side + SRAM write side)
module sram_wr_sched
    import sram_wr_sched_pkg::*;
#(
    parameter int fifo_data_width      = DEF_DATA_WIDTH,
    parameter int fifo_num_of_priority = DEF_NUM_PRIORITY,
    parameter int fifo_length          = DEF_FIFO_LENGTH
) (
    input  logic            clk,
    input  logic            rst,
    sram_wr_sched_if.master bus
);

    localparam int prio_w = clog2(fifo_num_of_priority);
    localparam int cnt_w  = clog2(fifo_length) + 1;

    sched_state_t state;
    sched_state_t state_nxt;

    logic [prio_w-1:0]               grant;
    logic [cnt_w-1:0]                count;
    logic [prio_w-1:0]               enc_idx;
    logic                            enc_vld;
    logic                            sel_vld;
    logic                            sel_eop;
    logic [fifo_data_width-1:0]      sel_data;
    logic                            accept;
    logic                            limit_hit;
    logic                            last_word;
    logic [fifo_num_of_priority-1:0] next_vec;

    logic                       wr_sop_q;
    logic                       wr_eop_q;
    logic                       wr_vld_q;
    logic [fifo_data_width-1:0] wr_data_q;
    logic [prio_w-1:0]          wr_prio_q;
    logic                       pkt_err_q;

    sram_wr_sched_prio_enc #(
        .num_req (fifo_num_of_priority),
        .idx_w   (prio_w)
    ) u_prio_enc (
        .req   (bus.q_ready),
        .idx   (enc_idx),
        .valid (enc_vld)
    );

    // Only the granted FIFO is looked at. A word is taken whenever it is
    // valid during XFER; the packet ends on eop or when the word that would
    // reach fifo_length arrives without one.
    always_comb begin
        sel_vld   = bus.q_vld[grant];
        sel_eop   = bus.q_eop[grant];
        sel_data  = bus.q_data[int'(grant)*fifo_data_width +: fifo_data_width];
        accept    = (state == ST_XFER) && sel_vld;
        limit_hit = (count == cnt_w'(fifo_length - 1));
        last_word = accept && (sel_eop || limit_hit);
    end

    // Next-state and q_next. q_next drops in the very cycle the last word is
    // accepted so the FIFO never pops a word belonging to the next packet
    // (or the tail of an overlong one, which upstream has to flush).
    always_comb begin
        state_nxt = state;
        next_vec  = '0;
        case (state)
            ST_IDLE: begin
                if ((|bus.q_ready) && (int'(bus.sram_free) >= fifo_length)) begin
                    state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                state_nxt = enc_vld ? ST_XFER : ST_IDLE;
            end
            ST_XFER: begin
                if (last_word) begin
                    state_nxt = ST_GAP;
                end else begin
                    next_vec[grant] = 1'b1;
                end
            end
            ST_GAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus grant/priority latch and word counter. The grant
    // is frozen in ARB, so later q_ready changes cannot steal the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            wr_prio_q <= '0;
            count     <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_ARB) begin
                grant     <= enc_idx;
                wr_prio_q <= enc_idx;
                count     <= '0;
            end else if (accept) begin
                count <= count + 1'b1;
            end
        end
    end

    // One-cycle output register towards SRAM. The first accepted word is
    // always marked sop whatever the FIFO flagged; an overlong packet gets a
    // forced eop together with a single pkt_err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_vld_q  <= 1'b0;
            wr_sop_q  <= 1'b0;
            wr_eop_q  <= 1'b0;
            wr_data_q <= '0;
            pkt_err_q <= 1'b0;
        end else begin
            wr_vld_q  <= accept;
            wr_sop_q  <= accept && (count == '0);
            wr_eop_q  <= last_word;
            wr_data_q <= accept ? sel_data : '0;
            pkt_err_q <= accept && limit_hit && !sel_eop;
        end
    end

    assign bus.q_next       = next_vec;
    assign bus.sram_wr_vld  = wr_vld_q;
    assign bus.sram_wr_sop  = wr_sop_q;
    assign bus.sram_wr_eop  = wr_eop_q;
    assign bus.sram_wr_data = wr_data_q;
    assign bus.sram_wr_prio = wr_prio_q;
    assign bus.pkt_err      = pkt_err_q;
    assign bus.busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_sram_wr_sched.sv
// tb_sram_wr_sched
//   Self-checking bench for sram_wr_sched. The bench owns a model of the
//   ingress FIFOs (queues of words answering q_next one cycle later) and of
//   the packet rules, and compares the SRAM port every cycle against it.
module tb_sram_wr_sched;
    import sram_wr_sched_pkg::*;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int L  = 32;
    localparam int PW = 3;
    localparam int FW = 9;

    typedef struct packed {
        logic [W-1:0] data;
        logic         sop;
        logic         eop;
    } word_t;

    typedef struct packed {
        logic [W-1:0]  data;
        logic          sop;
        logic          eop;
        logic          err;
        logic [PW-1:0] prio;
    } out_t;

    logic clk = 1'b0;
    logic rst;

    sram_wr_sched_if #(.data_w(W), .num_prio(N), .prio_w(PW), .free_w(FW)) bus ();

    sram_wr_sched #(
        .fifo_data_width      (W),
        .fifo_num_of_priority (N),
        .fifo_length          (L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    word_t fifo_q [N][$];
    int    pkt_cnt  [N];
    int    word_idx [N];
    out_t  out_log [$];

    logic [N-1:0]  next_s = '0;
    logic          pres_vld = 1'b0, pres_sop = 1'b0, pres_eop = 1'b0, pres_err = 1'b0;
    logic [W-1:0]  pres_data = '0;
    logic [PW-1:0] pres_prio = '0;
    logic          exp_vld = 1'b0, exp_sop = 1'b0, exp_eop = 1'b0, exp_err = 1'b0;
    logic [W-1:0]  exp_data = '0;
    logic [PW-1:0] exp_prio = '0;

    logic [N-1:0]  prev_next = '0, prev_ready = '0;
    logic          prev_busy = 1'b0, prev_eop = 1'b0;
    int            prev_free = 0;

    bit check_en = 1'b0, stall_en = 1'b0, push_en = 1'b0, free_rand_en = 1'b0;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [N-1:0] lowestBit(input logic [N-1:0] req);
        for (int i = 0; i < N; i++) begin
            if (req[i]) return N'(1) << i;
        end
        return '0;
    endfunction

    function automatic bit queuesEmpty();
        for (int i = 0; i < N; i++) begin
            if (fifo_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic pushPacket(input int f, input int len, input logic [W-1:0] base, input bit first_sop);
        word_t w;
        for (int k = 0; k < len; k++) begin
            w.data = base + W'(k);
            w.sop  = (k == 0) && first_sop;
            w.eop  = (k == len - 1);
            fifo_q[f].push_back(w);
        end
        pkt_cnt[f]++;
    endtask

    task automatic clearModel();
        for (int i = 0; i < N; i++) begin
            fifo_q[i].delete();
            pkt_cnt[i]  = 0;
            word_idx[i] = 0;
        end
        pres_vld = 1'b0; pres_sop = 1'b0; pres_eop = 1'b0; pres_err = 1'b0;
        exp_vld  = 1'b0; exp_sop  = 1'b0; exp_eop  = 1'b0; exp_err  = 1'b0;
        bus.q_ready = '0; bus.q_vld = '0; bus.q_sop = '0; bus.q_eop = '0; bus.q_data = '0;
    endtask

    // One clock of the FIFO model: what was on the FIFO outputs last cycle
    // becomes this cycle's expected SRAM word, then requested FIFOs pop.
    task automatic applyStimulus();
        word_t          w;
        word_t          w2;
        logic [N-1:0]   vld_v;
        logic [N-1:0]   sop_v;
        logic [N-1:0]   eop_v;
        logic [N*W-1:0] data_v;
        logic [N-1:0]   rdy_v;
        int             f;
        int             len;
        @(posedge clk);
        #1;
        exp_vld  = pres_vld;
        exp_sop  = pres_sop;
        exp_eop  = pres_eop;
        exp_err  = pres_err;
        exp_data = pres_data;
        exp_prio = pres_prio;
        pres_vld = 1'b0; pres_sop = 1'b0; pres_eop = 1'b0; pres_err = 1'b0;
        vld_v = '0;
        sop_v = N'($urandom);
        eop_v = N'($urandom);
        for (int i = 0; i < N; i++) data_v[i*W +: W] = W'($urandom);
        for (int i = 0; i < N; i++) begin
            if (next_s[i] && fifo_q[i].size() > 0 && !(stall_en && $urandom_range(3) == 0)) begin
                w = fifo_q[i].pop_front();
                word_idx[i]++;
                pres_vld  = 1'b1;
                pres_data = w.data;
                pres_prio = PW'(i);
                pres_sop  = (word_idx[i] == 1);
                pres_eop  = w.eop || (word_idx[i] == L);
                pres_err  = (word_idx[i] == L) && !w.eop;
                vld_v[i]  = 1'b1;
                sop_v[i]  = w.sop;
                eop_v[i]  = w.eop;
                data_v[i*W +: W] = w.data;
                if (w.eop) pkt_cnt[i]--;
                if (pres_eop) word_idx[i] = 0;
                if (pres_err) begin
                    while (fifo_q[i].size() > 0) begin
                        w2 = fifo_q[i].pop_front();
                        if (w2.eop) begin
                            pkt_cnt[i]--;
                            break;
                        end
                    end
                end
            end
        end
        if (push_en && $urandom_range(5) == 0) begin
            f = $urandom_range(N - 1);
            if (fifo_q[f].size() < 100) begin
                len = ($urandom_range(9) == 0) ? $urandom_range(40, L + 1) : $urandom_range(L - 1, 1);
                pushPacket(f, len, W'($urandom), $urandom_range(3) != 0);
            end
        end
        if (free_rand_en && $urandom_range(7) == 0) begin
            bus.sram_free = ($urandom_range(3) == 0) ? FW'($urandom_range(L - 1)) : FW'($urandom_range(256, L));
        end
        for (int i = 0; i < N; i++) rdy_v[i] = (pkt_cnt[i] > 0);
        bus.q_vld   = vld_v;
        bus.q_sop   = sop_v;
        bus.q_eop   = eop_v;
        bus.q_data  = data_v;
        bus.q_ready = rdy_v;
    endtask

    task automatic runUntilIdle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            applyStimulus();
            done = queuesEmpty() && !bus.busy && !pres_vld;
        end
        checkOutput(name, 32'(done), 32'd1);
        repeat (2) applyStimulus();
    endtask

    task automatic resetDut();
        check_en = 1'b0;
        rst      = 1'b1;
        clearModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_wr_vld",  32'(bus.sram_wr_vld),  32'd0);
        checkOutput("rst_wr_sop",  32'(bus.sram_wr_sop),  32'd0);
        checkOutput("rst_wr_eop",  32'(bus.sram_wr_eop),  32'd0);
        checkOutput("rst_pkt_err", 32'(bus.pkt_err),      32'd0);
        checkOutput("rst_wr_data", 32'(bus.sram_wr_data), 32'd0);
        checkOutput("rst_wr_prio", 32'(bus.sram_wr_prio), 32'd0);
        checkOutput("rst_busy",    32'(bus.busy),         32'd0);
        checkOutput("rst_q_next",  32'(bus.q_next),       32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        check_en = 1'b1;
    endtask

    always @(negedge clk) next_s = bus.q_next;

    // Per-cycle comparison of the SRAM port and q_next against the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("wr_vld",  32'(bus.sram_wr_vld), 32'(exp_vld));
            checkOutput("wr_sop",  32'(bus.sram_wr_sop), 32'(exp_sop));
            checkOutput("wr_eop",  32'(bus.sram_wr_eop), 32'(exp_eop));
            checkOutput("pkt_err", 32'(bus.pkt_err),     32'(exp_err));
            if (exp_vld) begin
                checkOutput("wr_data", 32'(bus.sram_wr_data), 32'(exp_data));
                checkOutput("wr_prio", 32'(bus.sram_wr_prio), 32'(exp_prio));
            end
            checkOutput("q_next_onehot0", 32'($onehot0(bus.q_next)), 32'd1);
            if (prev_next == '0 && bus.q_next != '0) begin
                checkOutput("arb_grant", 32'(bus.q_next), 32'(lowestBit(prev_ready)));
            end
            if (!prev_busy) begin
                checkOutput("admission", 32'(bus.busy), 32'((prev_ready != '0) && (prev_free >= L)));
            end
            if (prev_eop) begin
                checkOutput("gap_after_eop", 32'(bus.sram_wr_vld), 32'd0);
            end
        end
        if (bus.sram_wr_vld === 1'b1) begin
            out_log.push_back('{data: bus.sram_wr_data, sop: bus.sram_wr_sop, eop: bus.sram_wr_eop,
                                err: bus.pkt_err, prio: bus.sram_wr_prio});
        end
        prev_next  = bus.q_next;
        prev_ready = bus.q_ready;
        prev_busy  = bus.busy;
        prev_eop   = bus.sram_wr_eop;
        prev_free  = int'(bus.sram_free);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  exp3 [10];
        bit  seen;
        int  errs;
        exp3 = '{2, 2, 2, 5, 5, 7, 7, 7, 7, 7};
        rst = 1'b1;
        bus.sram_free = FW'(256);
        clearModel();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("init_wr_vld", 32'(bus.sram_wr_vld), 32'd0);
        checkOutput("init_busy",   32'(bus.busy),        32'd0);
        checkOutput("init_q_next", 32'(bus.q_next),      32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        check_en = 1'b1;
        repeat (2) applyStimulus();

        $display("[TB] single packet on FIFO3");
        out_log.delete();
        pushPacket(3, 4, 16'hA001, 1'b1);
        runUntilIdle("t2_idle", 60);
        checkOutput("t2_words", 32'(out_log.size()), 32'd4);
        if (out_log.size() == 4) begin
            checkOutput("t2_first_data", 32'(out_log[0].data), 32'hA001);
            checkOutput("t2_first_sop",  32'(out_log[0].sop),  32'd1);
            checkOutput("t2_prio",       32'(out_log[0].prio), 32'd3);
            checkOutput("t2_mid_sop",    32'(out_log[1].sop),  32'd0);
            checkOutput("t2_mid_eop",    32'(out_log[2].eop),  32'd0);
            checkOutput("t2_last_data",  32'(out_log[3].data), 32'hA004);
            checkOutput("t2_last_eop",   32'(out_log[3].eop),  32'd1);
        end

        $display("[TB] strict priority 2, 5, 7");
        out_log.delete();
        pushPacket(7, 5, 16'h7000, 1'b1);
        pushPacket(5, 2, 16'h5000, 1'b1);
        pushPacket(2, 3, 16'h2000, 1'b1);
        runUntilIdle("t3_idle", 100);
        checkOutput("t3_words", 32'(out_log.size()), 32'd10);
        for (int k = 0; k < 10 && k < out_log.size(); k++) begin
            checkOutput("t3_prio_order", 32'(out_log[k].prio), 32'(exp3[k]));
        end

        $display("[TB] higher priority arrives mid-packet");
        out_log.delete();
        pushPacket(4, 6, 16'h4400, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            applyStimulus();
            seen = next_s[4];
        end
        checkOutput("t4_grant_seen", 32'(seen), 32'd1);
        pushPacket(0, 3, 16'h0A00, 1'b0);
        runUntilIdle("t4_idle", 100);
        checkOutput("t4_words", 32'(out_log.size()), 32'd9);
        if (out_log.size() == 9) begin
            checkOutput("t4_fifo4_last_prio", 32'(out_log[5].prio), 32'd4);
            checkOutput("t4_fifo4_last_eop",  32'(out_log[5].eop),  32'd1);
            checkOutput("t4_fifo0_prio",      32'(out_log[6].prio), 32'd0);
            checkOutput("t4_forced_sop",      32'(out_log[6].sop),  32'd1);
            checkOutput("t4_fifo0_data",      32'(out_log[6].data), 32'h0A00);
        end

        $display("[TB] admission threshold");
        bus.sram_free = FW'(31);
        pushPacket(1, 2, 16'h1100, 1'b1);
        repeat (5) applyStimulus();
        @(negedge clk);
        checkOutput("t5_held_busy",   32'(bus.busy),   32'd0);
        checkOutput("t5_held_q_next", 32'(bus.q_next), 32'd0);
        applyStimulus();
        bus.sram_free = FW'(32);
        @(negedge clk);
        checkOutput("t5_still_idle", 32'(bus.busy), 32'd0);
        applyStimulus();
        @(negedge clk);
        checkOutput("t5_arb_next", 32'(bus.busy), 32'd1);
        runUntilIdle("t5_idle", 60);
        bus.sram_free = FW'(256);

        $display("[TB] overlong packet");
        out_log.delete();
        pushPacket(6, 33, 16'h6000, 1'b1);
        runUntilIdle("t6_idle", 120);
        checkOutput("t6_words", 32'(out_log.size()), 32'd32);
        if (out_log.size() == 32) begin
            checkOutput("t6_w31_eop",  32'(out_log[30].eop),  32'd0);
            checkOutput("t6_w32_eop",  32'(out_log[31].eop),  32'd1);
            checkOutput("t6_w32_err",  32'(out_log[31].err),  32'd1);
            checkOutput("t6_w32_data", 32'(out_log[31].data), 32'h601F);
        end
        errs = 0;
        foreach (out_log[k]) if (out_log[k].err) errs++;
        checkOutput("t6_err_pulses", 32'(errs), 32'd1);

        $display("[TB] reset mid-transfer");
        out_log.delete();
        pushPacket(1, 20, 16'h1200, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            applyStimulus();
            seen = (out_log.size() >= 3);
        end
        checkOutput("t1_xfer_reached", 32'(seen), 32'd1);
        resetDut();
        repeat (3) applyStimulus();

        $display("[TB] randomized traffic");
        stall_en     = 1'b1;
        push_en      = 1'b1;
        free_rand_en = 1'b1;
        repeat (3000) applyStimulus();
        push_en      = 1'b0;
        free_rand_en = 1'b0;
        bus.sram_free = FW'(256);
        runUntilIdle("drain_idle", 6000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
